// File: rtl/key_debouncer_if.sv
// Signal bundle between a raw push button pin and its debouncer.
// The slave side is the debouncer; the master side drives the pin and observes the events.
interface key_debouncer_if;
  logic       key_n;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic [1:0] dbg_state;

  // key_n is a free-running level with no handshake. The three event outputs
  // are registered: each is valid for the whole cycle after the clk edge that
  // sets it, and each pulse is high for exactly one cycle.
  modport slave (
    input  key_n,
    output pressed,
    output press_pulse,
    output release_pulse,
    output dbg_state
  );

  modport master (
    output key_n,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  dbg_state
  );
endinterface

// File: rtl/key_debouncer.sv
// Active-low push button debouncer: two-flop synchroniser, stability-count FSM, registered event pulses.
// Define KEY_DEBOUNCE_REPEAT_EN to build the hold-to-auto-repeat timer.
module key_debouncer #(
  parameter int STABLE_CYCLES = 8,
  parameter int REPEAT_DELAY  = 400,
  parameter int REPEAT_PERIOD = 80
) (
  input  logic               clk,
  input  logic               reset,
  key_debouncer_if.slave     kif
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (STABLE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("key_debouncer: STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 2");
  end

  // Synchroniser; the inversion makes raw active-high (1 = pressed).
  logic s1;
  logic s2;
  logic raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ~kif.key_n;
      s2 <= s1;
    end
  end

  assign raw = s2;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] cnt_inc;
  logic             pressed_q;
  logic             pressed_nx;
  logic             press_q;
  logic             press_nx;
  logic             release_q;
  logic             release_nx;
  logic             rpt_fire;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;
  logic             staying_held;

  // Timer only advances on cycles that remain in HELD, so any exit (including
  // a bounce into RELEASE_WAIT) restarts the full initial delay.
  assign staying_held = (state == HELD) && raw;
  assign rpt_fire     = staying_held &&
                        (rpt_armed ? (rpt_cnt == PERIOD_LAST) : (rpt_cnt == DELAY_LAST));

  always_ff @(posedge clk) begin
    if (reset || !staying_held) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pressed_q <= pressed_nx;
      press_q   <= press_nx;
      release_q <= release_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pressed_nx = pressed_q;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    case (state)
      IDLE: begin
        if (raw) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!raw) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = HELD;
          cnt_nx     = '0;
          pressed_nx = 1'b1;
          press_nx   = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      HELD: begin
        if (!raw) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = CNT_ONE;
        end else if (rpt_fire) begin
          press_nx = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (raw) begin
          state_nx = HELD;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          pressed_nx = 1'b0;
          release_nx = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign kif.pressed       = pressed_q;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = release_q;
  assign kif.dbg_state     = state;

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Debounces one active-low push button and produces clean, registered press/release events on the divided system clock. It sits between the raw `KEY[n]` pin and the `inc_ctr` increment input in the DE1-SoC top level, replacing the bare `dff` stage. It provides metastability synchronisation, a stability-count filter, and single-cycle event pulses, with optional hold-to-auto-repeat.

## Interface
Parameters:
- `STABLE_CYCLES`, default 8: consecutive identical synchronised samples required to accept a level change. Legal range is ≥ 2.
- `REPEAT_DELAY`, default 400: cycles in HELD before the first auto-repeat pulse. Legal range is ≥ 2.
- `REPEAT_PERIOD`, default 80: cycles between subsequent auto-repeat pulses. Legal range is ≥ 2, so that a downstream edge detector always sees a low cycle between pulses.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` — input, 1 bit: system clock (divided clock, about 763 Hz).
- `reset` — input, 1 bit: synchronous, active-high; all state cleared at the next `clk` edge.
- `key_n` — input, 1 bit: raw button, asynchronous, low = pressed.
- `pressed` — output, 1 bit: debounced level, 1 while the key is accepted as held.
- `press_pulse` — output, 1 bit: one-cycle pulse on an accepted press, and on each auto-repeat.
- `release_pulse` — output, 1 bit: one-cycle pulse on an accepted release.

## Operation
- **Synchroniser:** two flops, `s1 <= ~key_n`, `s2 <= s1`. `raw = s2`. Both flops reset to 0.
- **Stability counter:** `cnt`, width `$clog2(STABLE_CYCLES+1)`, saturating, cleared on every state change.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Reset state is IDLE.
  - **IDLE:** when `raw=1`, go to PRESS_WAIT with `cnt<=1`.
  - **PRESS_WAIT:**
    - `raw=0`: go to IDLE, `cnt<=0`.
    - `raw=1` and `cnt==STABLE_CYCLES-1`: go to HELD, `pressed<=1`, `press_pulse<=1`.
    - Otherwise: `cnt++`.
  - **HELD:** when `raw=0`, go to RELEASE_WAIT with `cnt<=1`.
  - **RELEASE_WAIT:**
    - `raw=1`: go back to HELD with `cnt<=0`. No pulse is generated and the repeat timer restarts.
    - `raw=0` and `cnt==STABLE_CYCLES-1`: go to IDLE, `pressed<=0`, `release_pulse<=1`.
    - Otherwise: `cnt++`.
- **Outputs:** all outputs are registered.
  - `press_pulse` and `release_pulse` are never high in the same cycle.
  - Each pulse lasts exactly one cycle.
- **Reset values:** after a reset edge, `pressed=0`, `press_pulse=0`, `release_pulse=0`, state is IDLE, `cnt=0`, and the repeat timer is 0.
- **Reset mid-operation:** reset aborts any partial count. A key still held after reset must re-qualify for the full `STABLE_CYCLES` before any pulse.

## Timing
- **Press latency:** `key_n` is low at rising edge k and stays low.
  - `pressed` and `press_pulse` are high after edge k+STABLE_CYCLES+1.
  - `press_pulse` drops after edge k+STABLE_CYCLES+2.
- **Release latency:** symmetric to press. `key_n` is high from edge r, so `pressed` falls and `release_pulse` rises after edge r+STABLE_CYCLES+1.
- **Glitch rejection:** a `raw` excursion shorter than `STABLE_CYCLES` samples never changes `pressed` and never pulses.
- **Throughput:** at most one accepted transition per `STABLE_CYCLES` cycles.

## Configuration
- **Macro:** `KEY_DEBOUNCE_REPEAT_EN`.
- **Defined (auto-repeat enabled):**
  - A repeat timer runs while in HELD and clears on leaving HELD.
  - With the initial `press_pulse` after edge e, repeat pulses occur after edges e+REPEAT_DELAY, e+REPEAT_DELAY+REPEAT_PERIOD, e+REPEAT_DELAY+2·REPEAT_PERIOD, …, until the FSM leaves HELD.
  - After a bounce RELEASE_WAIT→HELD, the next repeat occurs REPEAT_DELAY cycles after re-entry to HELD.
- **Undefined (auto-repeat disabled):**
  - No repeat timer logic is built.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are accepted but unused.
  - Exactly one `press_pulse` occurs per accepted press.

## Test plan
- **Reset:** `reset=1` for 2 cycles with `key_n=1`, then `key_n=0` for 2 cycles with `reset` still high → `pressed=0`, `press_pulse=0`, `release_pulse=0` throughout.
- **Clean press, `STABLE_CYCLES=4`:** `key_n` falls before edge 0 and is held → `pressed`=1 and `press_pulse`=1 after edge 5; `press_pulse`=0 after edge 6; exactly 1 pulse total.
- **Press bounce, `STABLE_CYCLES=4`:** `key_n` pattern low 3 cycles, high 1, low 3, high 1, then low steady → no pulse during the bounce; exactly one `press_pulse`, 5 edges after the final falling sample.
- **Release glitch, `STABLE_CYCLES=4`:**
  - While HELD, `key_n` goes high for 2 cycles → `pressed` stays 1, no `release_pulse`.
  - Then `key_n` goes high from edge r → `release_pulse` for one cycle after edge r+5, `pressed`=0.
- **Reset mid-PRESS_WAIT:** `key_n` low for 3 cycles, `reset` pulsed 1 cycle, `key_n` kept low → no pulse before reset; `press_pulse` occurs only after a full re-qualification counted from the post-reset sampling.
- **Auto-repeat, `STABLE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`:** hold the key for 30 cycles past edge e → with the macro, pulses after e, e+10, e+13, e+16, …; without the macro, a single pulse after e only.
